// File: rtl/counter_core_pkg.sv
// Default geometry for counter_core instances.
// Instances that need another width or step override the parameters directly.
package counter_core_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_STEP  = 1;

endpackage

// File: rtl/counter_core.sv
// Enable-gated modulo-2^WIDTH up-counter with a registered count, a terminal-count
// decode and a one-cycle wrap pulse for cascading counters or building timers.
module counter_core
  import counter_core_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned STEP  = DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  // The largest count that can still advance by STEP without overflowing.
  localparam logic [WIDTH-1:0] TC_LIMIT = {WIDTH{1'b1}} - WIDTH'(STEP);

  logic [WIDTH:0] sum;

  // One extra bit holds the carry, so overflow is visible without a compare.
  assign sum = {1'b0, out} + (WIDTH + 1)'(STEP);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep out and wrap sampling the same pre-edge
    // values; blocking ones would make the result depend on statement order.
    if (reset) begin
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= enable & sum[WIDTH];
      if (enable) begin
        out <= sum[WIDTH-1:0];
      end
    end
  end

  assign tc = (out > TC_LIMIT);

endmodule

// File: tb/tb_counter_core.sv
// Directed bench for counter_core: default WIDTH=8/STEP=1 instance plus a
// WIDTH=4/STEP=3 instance for non-unit steps and tc decoding.
module tb_counter_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] out;
  logic       tc;
  logic       wrap;

  logic       reset4;
  logic       enable4;
  logic [3:0] out4;
  logic       tc4;
  logic       wrap4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  counter_core dut8 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .out    (out),
    .tc     (tc),
    .wrap   (wrap)
  );

  counter_core #(.WIDTH(4), .STEP(3)) dut4 (
    .clk    (clk),
    .reset  (reset4),
    .enable (enable4),
    .out    (out4),
    .tc     (tc4),
    .wrap   (wrap4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input int exp_out, input bit exp_tc, input bit exp_wrap);
    check({tag, ".out"},  32'(out),  32'(exp_out));
    check({tag, ".tc"},   32'(tc),   32'(exp_tc));
    check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  // Expected WIDTH=4, STEP=3 sequence from 0, worked by hand.
  int exp4_out  [16] = '{3, 6, 9, 12, 15, 2, 5, 8, 11, 14, 1, 4, 7, 10, 13, 0};
  bit exp4_tc   [16] = '{0, 0, 0, 0,  1,  0, 0, 0, 0,  1,  0, 0, 0, 0,  1,  0};
  bit exp4_wrap [16] = '{0, 0, 0, 0,  0,  1, 0, 0, 0,  0,  1, 0, 0, 0,  0,  1};

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    reset4  = 1'b1;
    enable4 = 1'b0;

    // Reset with enable high.
    tick();
    check8("reset", 0, 1'b0, 1'b0);
    tick();
    check8("reset_hold", 0, 1'b0, 1'b0);

    // Count 50 edges, checking +1 per edge.
    reset = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      check($sformatf("count%0d", i), 32'(out), 32'(i));
    end
    check8("count50", 8'h32, 1'b0, 1'b0);

    // Hold at 20.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check8("pre_hold", 20, 1'b0, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check8($sformatf("hold%0d", i), 20, 1'b0, 1'b0);
    end
    enable = 1'b1;
    tick();
    check8("resume", 21, 1'b0, 1'b0);

    // Mid-run reset at 37, enable kept high.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (37) tick();
    check8("pre_midreset", 37, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check8("midreset", 0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check8($sformatf("post_reset%0d", i), i, 1'b0, 1'b0);
    end

    // Wrap: 0 -> 0xFF, hold at 0xFF (no wrap), then overflow.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (254) tick();
    check8("at_fe", 8'hFE, 1'b0, 1'b0);
    tick();
    check8("at_ff", 8'hFF, 1'b1, 1'b0);
    enable = 1'b0;
    tick();
    check8("ff_disabled", 8'hFF, 1'b1, 1'b0);
    enable = 1'b1;
    tick();
    check8("wrap_edge", 8'h00, 1'b0, 1'b1);
    tick();
    check8("after_wrap", 8'h01, 1'b0, 1'b0);

    // Reset beats enable even at the overflow point.
    repeat (254) tick();
    check8("at_ff2", 8'hFF, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check8("reset_at_ff", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    enable = 1'b0;

    // WIDTH=4, STEP=3 instance.
    tick();
    check("w4.reset.out", 32'(out4), 32'd0);
    check("w4.reset.wrap", 32'(wrap4), 32'd0);
    reset4  = 1'b0;
    enable4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("w4.step%0d.out", i),  32'(out4),  32'(exp4_out[i]));
      check($sformatf("w4.step%0d.tc", i),   32'(tc4),   32'(exp4_tc[i]));
      check($sformatf("w4.step%0d.wrap", i), 32'(wrap4), 32'(exp4_wrap[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
